// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue
// In-order FIFO of predicted branches between fetch and EX. Each resolve pops
// the oldest entry, emits a registered predictor update and, when the
// prediction was wrong, a one-cycle mispredict strobe with the redirect PC
// while flushing every younger (wrong-path) entry.
//
// Ports:
//   clk, rst (async, active-low)
//   push_valid/push_pred/push_idx/push_pc/push_target : new predicted branch
//   resolve_valid/resolve_taken/resolve_target        : outcome of the head
//   full, empty                                       : combinational from count
//   count                                             : occupancy
//   upd_valid/upd_taken/upd_idx                       : predictor update (registered)
//   mispredict/redirect_pc                            : flush/redirect (registered)
//   underflow                                         : sticky resolve-on-empty
//   mispredict_cnt                                    : saturating mispredict counter
module branch_resolve_queue #(
  parameter int unsigned GSHARE_BITS_NUM      = 5,
  parameter int unsigned OPTION_OPERAND_WIDTH = 10,
  parameter int unsigned DEPTH                = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              push_valid,
  input  logic                              push_pred,
  input  logic [GSHARE_BITS_NUM-1:0]        push_idx,
  input  logic [OPTION_OPERAND_WIDTH-1:0]   push_pc,
  input  logic [OPTION_OPERAND_WIDTH-1:0]   push_target,
  input  logic                              resolve_valid,
  input  logic                              resolve_taken,
  input  logic [OPTION_OPERAND_WIDTH-1:0]   resolve_target,
  output logic                              full,
  output logic                              empty,
  output logic [$clog2(DEPTH):0]            count,
  output logic                              upd_valid,
  output logic                              upd_taken,
  output logic [GSHARE_BITS_NUM-1:0]        upd_idx,
  output logic                              mispredict,
  output logic [OPTION_OPERAND_WIDTH-1:0]   redirect_pc,
  output logic                              underflow,
  output logic [15:0]                       mispredict_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned PC_W  = OPTION_OPERAND_WIDTH;

  typedef struct packed {
    logic                       pred;
    logic [GSHARE_BITS_NUM-1:0] idx;
    logic [PC_W-1:0]            pc;
    logic [PC_W-1:0]            target;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  entry_t           head_c;
  logic             do_resolve_c;
  logic             mis_c;
  logic             push_ok_c;
  logic [PC_W-1:0]  redirect_c;

  // Status flags straight from the occupancy count.
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // Head evaluation, mispredict detection and push acceptance.
  always_comb begin
    head_c       = mem[rd_ptr];
    do_resolve_c = resolve_valid && !empty;
    mis_c        = 1'b0;
    redirect_c   = head_c.pc + PC_W'(1);
    if (do_resolve_c) begin
      mis_c = (head_c.pred != resolve_taken) ||
              (head_c.pred && resolve_taken && (head_c.target != resolve_target));
    end
    if (resolve_taken) begin
      redirect_c = resolve_target;
    end
    // A pop in the same cycle frees a slot; a mispredict makes the push wrong-path.
    push_ok_c = push_valid && !mis_c && (!full || do_resolve_c);
  end

  // Entry storage; not reset, validity is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    if (push_ok_c) begin
      mem[wr_ptr] <= '{pred: push_pred, idx: push_idx, pc: push_pc, target: push_target};
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (mis_c) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_resolve_c) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_ok_c)    wr_ptr <= wr_ptr + PTR_W'(1);
      unique case ({push_ok_c, do_resolve_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Predictor update, redirect and error/statistics outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      upd_valid      <= 1'b0;
      upd_taken      <= 1'b0;
      upd_idx        <= '0;
      mispredict     <= 1'b0;
      redirect_pc    <= '0;
      underflow      <= 1'b0;
      mispredict_cnt <= '0;
    end else begin
      upd_valid  <= do_resolve_c;
      mispredict <= mis_c;
      if (do_resolve_c) begin
        upd_taken <= resolve_taken;
        upd_idx   <= head_c.idx;
      end
      if (mis_c) begin
        redirect_pc <= redirect_c;
        if (mispredict_cnt != 16'hFFFF) mispredict_cnt <= mispredict_cnt + 16'd1;
      end
      if (resolve_valid && empty) underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Randomized and directed bench for branch_resolve_queue against a queue-based
// reference model.
module tb_branch_resolve_queue;

  localparam int unsigned GB = 5;
  localparam int unsigned OW = 10;
  localparam int unsigned D  = 4;
  localparam int unsigned CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          push_valid, push_pred, resolve_valid, resolve_taken;
  logic [GB-1:0] push_idx;
  logic [OW-1:0] push_pc, push_target, resolve_target;
  logic          full, empty, upd_valid, upd_taken, mispredict, underflow;
  logic [CW-1:0] count;
  logic [GB-1:0] upd_idx;
  logic [OW-1:0] redirect_pc;
  logic [15:0]   mispredict_cnt;

  int vectors     = 0;
  int miscompares = 0;

  branch_resolve_queue #(.GSHARE_BITS_NUM(GB), .OPTION_OPERAND_WIDTH(OW), .DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .push_valid(push_valid), .push_pred(push_pred), .push_idx(push_idx),
    .push_pc(push_pc), .push_target(push_target),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
    .resolve_target(resolve_target),
    .full(full), .empty(empty), .count(count),
    .upd_valid(upd_valid), .upd_taken(upd_taken), .upd_idx(upd_idx),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .underflow(underflow), .mispredict_cnt(mispredict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          pred;
    logic [GB-1:0] idx;
    logic [OW-1:0] pc;
    logic [OW-1:0] target;
  } ent_t;

  ent_t          mq[$];
  logic          m_upd_valid, m_upd_taken, m_mis, m_underflow;
  logic [GB-1:0] m_upd_idx;
  logic [OW-1:0] m_redirect;
  int            m_cnt;

  task automatic model_reset();
    mq.delete();
    m_upd_valid = 0; m_upd_taken = 0; m_upd_idx = '0; m_mis = 0;
    m_redirect = '0; m_underflow = 0; m_cnt = 0;
  endtask

  // Drive one cycle of stimulus, advance the model, and return at edge+1.
  task automatic apply(input logic pv, input logic pp, input logic [GB-1:0] pi,
                       input logic [OW-1:0] ppc, input logic [OW-1:0] pt,
                       input logic rv, input logic rt, input logic [OW-1:0] rtg);
    int   sz0;
    bit   popped, mis;
    ent_t h, e;
    push_valid = pv; push_pred = pp; push_idx = pi; push_pc = ppc; push_target = pt;
    resolve_valid = rv; resolve_taken = rt; resolve_target = rtg;
    sz0 = mq.size(); popped = 0; mis = 0;
    m_upd_valid = 0; m_mis = 0;
    if (rv) begin
      if (sz0 == 0) m_underflow = 1;
      else begin
        h = mq[0]; popped = 1;
        m_upd_valid = 1; m_upd_taken = rt; m_upd_idx = h.idx;
        mis = (h.pred != rt) || (h.pred && rt && h.target != rtg);
        if (mis) begin
          m_mis = 1;
          m_redirect = rt ? rtg : OW'((int'(h.pc) + 1) % (1 << OW));
          if (m_cnt < 65535) m_cnt++;
          mq.delete();
        end else void'(mq.pop_front());
      end
    end
    if (pv && !mis && (sz0 < int'(D) || popped)) begin
      e.pred = pp; e.idx = pi; e.pc = ppc; e.target = pt;
      mq.push_back(e);
    end
    @(posedge clk); #1;
    push_valid = 0; resolve_valid = 0;
  endtask

  task automatic idle();
    apply(0, 0, '0, '0, '0, 0, 0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 0;
    model_reset();
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    vectors++;
    if ({count, empty, full, upd_valid, upd_taken, upd_idx, mispredict, redirect_pc,
         underflow, mispredict_cnt} !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 10'd0, 1'b0, 16'd0}) begin
      miscompares++;
      $display("FAIL reset_state: got count=%0d empty=%b full=%b uv=%b ut=%b ui=%h mis=%b rpc=%h uf=%b mc=%0d",
               count, empty, full, upd_valid, upd_taken, upd_idx, mispredict, redirect_pc, underflow, mispredict_cnt);
    end
  endtask

  task automatic test_correct_resolve();
    do_reset();
    apply(1, 1, 5'h0A, 10'h010, 10'h020, 0, 0, '0);
    vectors++;
    if (count !== 3'd1) begin miscompares++; $display("FAIL push_count: got %0d expected 1", count); end
    apply(0, 0, '0, '0, '0, 1, 1, 10'h020);
    vectors++;
    if ({upd_valid, upd_taken, upd_idx, mispredict, count} !== {1'b1, 1'b1, 5'h0A, 1'b0, 3'd0}) begin
      miscompares++;
      $display("FAIL correct_resolve: got uv=%b ut=%b ui=%h mis=%b count=%0d expected 1 1 0a 0 0",
               upd_valid, upd_taken, upd_idx, mispredict, count);
    end
    idle();
    vectors++;
    if (upd_valid !== 1'b0 || upd_idx !== 5'h0A) begin
      miscompares++; $display("FAIL upd_one_cycle: got uv=%b ui=%h expected 0 0a", upd_valid, upd_idx);
    end
  endtask

  task automatic test_mispredict();
    do_reset();
    apply(1, 0, 5'h03, 10'h3FF, 10'h000, 0, 0, '0);
    apply(0, 0, '0, '0, '0, 1, 1, 10'h100);
    vectors++;
    if ({mispredict, redirect_pc, mispredict_cnt} !== {1'b1, 10'h100, 16'd1}) begin
      miscompares++;
      $display("FAIL mispredict_taken: got mis=%b rpc=%h mc=%0d expected 1 100 1", mispredict, redirect_pc, mispredict_cnt);
    end
    idle();
    vectors++;
    if (mispredict !== 1'b0 || redirect_pc !== 10'h100) begin
      miscompares++; $display("FAIL mispredict_pulse: got mis=%b rpc=%h expected 0 100", mispredict, redirect_pc);
    end
    apply(1, 1, 5'h04, 10'h3FF, 10'h055, 0, 0, '0);
    apply(0, 0, '0, '0, '0, 1, 0, 10'h123);
    vectors++;
    if ({mispredict, redirect_pc, mispredict_cnt} !== {1'b1, 10'h000, 16'd2}) begin
      miscompares++;
      $display("FAIL redirect_wrap: got mis=%b rpc=%h mc=%0d expected 1 000 2", mispredict, redirect_pc, mispredict_cnt);
    end
  endtask

  task automatic test_full_and_wrap();
    logic [GB-1:0] exp_idx[4];
    do_reset();
    apply(1, 0, 5'd1, 10'h001, '0, 0, 0, '0); // advance pointers so drain wraps
    apply(0, 0, '0, '0, '0, 1, 0, '0);
    for (int i = 1; i <= 4; i++) apply(1, 0, GB'(i), OW'(i), '0, 0, 0, '0);
    apply(1, 0, 5'd5, 10'h005, '0, 0, 0, '0);
    vectors++;
    if (count !== 3'd4 || full !== 1'b1) begin
      miscompares++; $display("FAIL full_drop: got count=%0d full=%b expected 4 1", count, full);
    end
    apply(1, 0, 5'd6, 10'h006, '0, 1, 0, '0);
    vectors++;
    if (count !== 3'd4 || upd_idx !== 5'd1) begin
      miscompares++; $display("FAIL push_pop_full: got count=%0d ui=%h expected 4 01", count, upd_idx);
    end
    exp_idx[0] = 5'd2; exp_idx[1] = 5'd3; exp_idx[2] = 5'd4; exp_idx[3] = 5'd6;
    for (int i = 0; i < 4; i++) begin
      apply(0, 0, '0, '0, '0, 1, 0, '0);
      vectors++;
      if (upd_valid !== 1'b1 || upd_idx !== exp_idx[i] || mispredict !== 1'b0) begin
        miscompares++;
        $display("FAIL fifo_order[%0d]: got uv=%b ui=%h mis=%b expected 1 %h 0", i, upd_valid, upd_idx, mispredict, exp_idx[i]);
      end
    end
    vectors++;
    if (empty !== 1'b1) begin miscompares++; $display("FAIL drain_empty: got %b expected 1", empty); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 3; i++) apply(1, 1, GB'(i + 8), OW'(i), 10'h0F0, 0, 0, '0);
    apply(1, 1, 5'h1F, 10'h2AA, 10'h0F0, 1, 0, '0);
    vectors++;
    if ({count, empty, mispredict, redirect_pc} !== {3'd0, 1'b1, 1'b1, 10'h001}) begin
      miscompares++;
      $display("FAIL flush: got count=%0d empty=%b mis=%b rpc=%h expected 0 1 1 001", count, empty, mispredict, redirect_pc);
    end
    idle();
    vectors++;
    if (count !== 3'd0 || upd_valid !== 1'b0) begin
      miscompares++; $display("FAIL flush_no_enqueue: got count=%0d uv=%b expected 0 0", count, upd_valid);
    end
  endtask

  task automatic test_random();
    logic pv, pp, rv, rt;
    logic [OW-1:0] tg;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      pv = ($urandom_range(0, 99) < 60);
      pp = $urandom_range(0, 1);
      rv = ($urandom_range(0, 99) < 45);
      rt = $urandom_range(0, 1);
      tg = OW'($urandom_range(0, 3) * 16);
      if (mq.size() != 0 && $urandom_range(0, 99) < 75) begin
        rt = mq[0].pred; tg = mq[0].target;
      end
      apply(pv, pp, GB'($urandom), OW'($urandom), OW'($urandom_range(0, 3) * 16), rv, rt, tg);
      vectors++;
      if (count !== CW'(mq.size()) || empty !== (mq.size() == 0) || full !== (mq.size() == int'(D))) begin
        miscompares++;
        $display("FAIL rand_occupancy[%0d]: got count=%0d empty=%b full=%b expected count=%0d", n, count, empty, full, mq.size());
      end
      vectors++;
      if ({upd_valid, upd_taken, upd_idx} !== {m_upd_valid, m_upd_taken, m_upd_idx}) begin
        miscompares++;
        $display("FAIL rand_update[%0d]: got %b %b %h expected %b %b %h", n, upd_valid, upd_taken, upd_idx,
                 m_upd_valid, m_upd_taken, m_upd_idx);
      end
      vectors++;
      if ({mispredict, redirect_pc, underflow} !== {m_mis, m_redirect, m_underflow} || mispredict_cnt !== 16'(m_cnt)) begin
        miscompares++;
        $display("FAIL rand_redirect[%0d]: got mis=%b rpc=%h uf=%b mc=%0d expected %b %h %b %0d", n, mispredict,
                 redirect_pc, underflow, mispredict_cnt, m_mis, m_redirect, m_underflow, m_cnt);
      end
    end
  endtask

  task automatic test_underflow_async_reset();
    do_reset();
    apply(0, 0, '0, '0, '0, 1, 1, 10'h111);
    vectors++;
    if (underflow !== 1'b1 || upd_valid !== 1'b0 || mispredict !== 1'b0) begin
      miscompares++; $display("FAIL underflow: got uf=%b uv=%b mis=%b expected 1 0 0", underflow, upd_valid, mispredict);
    end
    idle();
    vectors++;
    if (underflow !== 1'b1) begin miscompares++; $display("FAIL underflow_sticky: got %b expected 1", underflow); end
    apply(1, 0, 5'h07, 10'h070, '0, 0, 0, '0);
    apply(1, 1, 5'h08, 10'h080, 10'h0AA, 0, 0, '0);
    #2 rst = 0;
    #1;
    vectors++;
    if ({count, empty, full, upd_valid, upd_taken, upd_idx, mispredict, redirect_pc,
         underflow, mispredict_cnt} !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 10'd0, 1'b0, 16'd0}) begin
      miscompares++;
      $display("FAIL async_reset: got count=%0d empty=%b full=%b uv=%b ui=%h mis=%b rpc=%h uf=%b mc=%0d",
               count, empty, full, upd_valid, upd_idx, mispredict, redirect_pc, underflow, mispredict_cnt);
    end
    model_reset();
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
    apply(1, 0, 5'h09, 10'h090, '0, 1, 1, 10'h0AA); // resolve on empty: the discarded entries must not appear
    vectors++;
    if (upd_valid !== 1'b0 || mispredict !== 1'b0 || count !== 3'd1 || underflow !== 1'b1) begin
      miscompares++;
      $display("FAIL post_reset_discard: got uv=%b mis=%b count=%0d uf=%b expected 0 0 1 1", upd_valid, mispredict, count, underflow);
    end
  endtask

  initial begin
    rst = 0;
    push_valid = 0; push_pred = 0; push_idx = '0; push_pc = '0; push_target = '0;
    resolve_valid = 0; resolve_taken = 0; resolve_target = '0;
    model_reset();
    #1;
    test_reset();
    test_correct_resolve();
    test_mispredict();
    test_full_and_wrap();
    test_flush();
    test_random();
    test_underflow_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
